// File: rtl/ex_mdu_ctrl.sv
// EX-stage sequencer for the shared multiplier and divider: owns the EX valid bit,
// issues start/cancel pulses and holds the selected result until MEM accepts it.
module ex_mdu_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pipe_flush,
    input  logic                id_ex_valid,
    output logic                ex_allowin,
    output logic                ex_valid,
    output logic                ex_mem_valid,
    input  logic                mem_allowin,
    input  logic                ex_is_mul_inst,
    input  logic                ex_is_div_inst,
    input  logic                ex_word_sel,
    input  logic                ex_div_sign,
    input  logic                ex_div_res_sel,
    input  logic [XLEN-1:0]     ex_rs1,
    input  logic [XLEN-1:0]     ex_rs2,
    output logic                mul_start,
    input  logic [2*XLEN-1:0]   mul_product,
    output logic                div_start,
    output logic                div_cancel,
    input  logic                div_done,
    input  logic [XLEN-1:0]     div_quotient,
    input  logic [XLEN-1:0]     div_remainder,
    output logic                mdu_busy,
    output logic [XLEN-1:0]     mdu_result
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ex_valid;
    logic [XLEN-1:0]  r_mdu_result;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_res_load;
    logic [XLEN-1:0]  w_res_nxt;
    logic             w_mul_start;
    logic             w_div_start;
    logic             w_div_by_zero;
    logic             w_div_ovf;
    logic             w_ready_go;
    logic             w_allowin;

    // Divide corner cases that RISC-V defines without needing the divider
    assign w_div_by_zero = (ex_rs2 == {XLEN{1'b0}});
    assign w_div_ovf     = ex_div_sign & (ex_rs1 == INT_MIN) & (ex_rs2 == ALL_ONES);

    assign w_ready_go = (~ex_is_mul_inst & ~ex_is_div_inst) | (r_state == S_DONE);
    assign w_allowin  = ~r_ex_valid | (w_ready_go & mem_allowin);

    assign ex_allowin   = w_allowin;
    assign ex_valid     = r_ex_valid;
    assign ex_mem_valid = r_ex_valid & w_ready_go;
    assign mul_start    = w_mul_start;
    assign div_start    = w_div_start;
    assign div_cancel   = pipe_flush & (r_state == S_DIV_WAIT);
    assign mdu_busy     = (r_state != S_IDLE);
    assign mdu_result   = r_mdu_result;

    // Next-state, start pulses and result capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_load  = 1'b0;
        w_res_nxt   = {XLEN{1'b0}};
        w_mul_start = 1'b0;
        w_div_start = 1'b0;
        if (pipe_flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ex_valid & ex_is_mul_inst) begin
                        w_mul_start = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = S_MUL_WAIT;
                    end else if (r_ex_valid & ex_is_div_inst) begin
                        if (w_div_by_zero) begin
                            w_res_load  = 1'b1;
                            w_res_nxt   = ex_div_res_sel ? ex_rs1 : ALL_ONES;
                            w_state_nxt = S_DONE;
                        end else if (w_div_ovf) begin
                            w_res_load  = 1'b1;
                            w_res_nxt   = ex_div_res_sel ? {XLEN{1'b0}} : ex_rs1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_div_start = 1'b1;
                            w_state_nxt = S_DIV_WAIT;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_MUL_WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        w_res_load  = 1'b1;
                        w_res_nxt   = ex_word_sel ? mul_product[2*XLEN-1:XLEN]
                                                  : mul_product[XLEN-1:0];
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_DIV_WAIT: begin
                    if (div_done) begin
                        w_res_load  = 1'b1;
                        w_res_nxt   = ex_div_res_sel ? div_remainder : div_quotient;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DIV_WAIT;
                    end
                end
                S_DONE: begin
                    // Leaving DONE coincides with the next instruction loading into EX
                    if (mem_allowin) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, latency counter, EX valid bit and held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_ex_valid   <= 1'b0;
            r_mdu_result <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (pipe_flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_allowin) begin
                r_ex_valid <= id_ex_valid;
            end else begin
                r_ex_valid <= r_ex_valid;
            end
            if (w_res_load) begin
                r_mdu_result <= w_res_nxt;
            end else begin
                r_mdu_result <= r_mdu_result;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Bench for ex_mdu_ctrl: directed vector table, flush/stall sequences and a
// randomized instruction stream checked against a transaction-level model.
module tb_ex_mdu_ctrl;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n, pipe_flush, id_ex_valid, mem_allowin;
    logic              ex_allowin, ex_valid, ex_mem_valid;
    logic              ex_is_mul_inst, ex_is_div_inst, ex_word_sel, ex_div_sign, ex_div_res_sel;
    logic [XLEN-1:0]   ex_rs1, ex_rs2;
    logic              mul_start, div_start, div_cancel, div_done, mdu_busy;
    logic [2*XLEN-1:0] mul_product;
    logic [XLEN-1:0]   div_quotient, div_remainder, mdu_result;
    logic              model_done, stray_done;

    always #5 clk = ~clk;

    ex_mdu_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .id_ex_valid(id_ex_valid),
        .ex_allowin(ex_allowin), .ex_valid(ex_valid), .ex_mem_valid(ex_mem_valid),
        .mem_allowin(mem_allowin), .ex_is_mul_inst(ex_is_mul_inst),
        .ex_is_div_inst(ex_is_div_inst), .ex_word_sel(ex_word_sel),
        .ex_div_sign(ex_div_sign), .ex_div_res_sel(ex_div_res_sel),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mul_start(mul_start), .mul_product(mul_product),
        .div_start(div_start), .div_cancel(div_cancel), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .mdu_busy(mdu_busy), .mdu_result(mdu_result)
    );

    typedef struct {
        bit          mul; bit div; bit wsel; bit dsign; bit rsel;
        logic [31:0] rs1; logic [31:0] rs2;
        int          dlat; int stall; int flush_age;
        logic [31:0] exp_res; int exp_lat; bit exp_dstart; bit chk_res;
    } instr_t;

    instr_t cur;
    instr_t offer_q[$];
    bit     live, flushed_last;
    int     entry, cyc, stall_left;
    int     n_pass = 0, n_total = 0;

    function automatic logic [63:0] divide(logic [31:0] a, logic [31:0] b, bit sgn);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        if (sgn) return {32'(sa / sb), 32'(sa % sb)};
        else     return {a / b, a % b};
    endfunction

    // Fixed-latency multiplier: product is valid only in cycle start+MUL_LAT
    logic [63:0] mul_d [MUL_LAT];
    logic        mul_v [MUL_LAT];
    always @(posedge clk) begin
        for (int i = MUL_LAT - 1; i > 0; i--) begin
            mul_v[i] <= mul_v[i-1];
            mul_d[i] <= mul_d[i-1];
        end
        mul_v[0] <= mul_start;
        mul_d[0] <= {32'd0, ex_rs1} * {32'd0, ex_rs2};
    end
    assign mul_product = (mul_v[MUL_LAT-1] === 1'b1) ? mul_d[MUL_LAT-1] : 64'hDEAD_BEEF_0BAD_F00D;

    // Iterative divider: done pulse cur.dlat cycles after start unless cancelled
    logic        dv_busy = 1'b0;
    int          dv_left = 0;
    logic [31:0] dv_q, dv_r;
    always @(posedge clk) begin
        if (dv_busy) begin
            if (div_cancel || dv_left == 0) dv_busy <= 1'b0;
            else                            dv_left <= dv_left - 1;
        end else if (div_start) begin
            dv_busy        <= 1'b1;
            dv_left        <= cur.dlat - 1;
            {dv_q, dv_r}   <= divide(ex_rs1, ex_rs2, ex_div_sign);
        end
    end
    assign model_done    = dv_busy && (dv_left == 0);
    assign div_done      = model_done | stray_done;
    assign div_quotient  = model_done ? dv_q : 32'h5A5A_5A5A;
    assign div_remainder = model_done ? dv_r : 32'hA5A5_A5A5;

    // Architectural result and latency of one instruction
    function automatic instr_t ref_model(instr_t x);
        instr_t      y;
        logic [63:0] p, qr;
        y = x; y.exp_dstart = 1'b0; y.chk_res = 1'b1;
        if (x.mul) begin
            p = {32'd0, x.rs1} * {32'd0, x.rs2};
            y.exp_res = x.wsel ? p[63:32] : p[31:0];
            y.exp_lat = MUL_LAT + 1;
        end else if (x.div) begin
            if (x.rs2 == 32'd0) begin
                qr = {32'hFFFF_FFFF, x.rs1}; y.exp_lat = 1;
            end else if (x.dsign && x.rs1 == 32'h8000_0000 && x.rs2 == 32'hFFFF_FFFF) begin
                qr = {x.rs1, 32'd0}; y.exp_lat = 1;
            end else begin
                qr = divide(x.rs1, x.rs2, x.dsign); y.exp_lat = x.dlat + 1; y.exp_dstart = 1'b1;
            end
            y.exp_res = x.rsel ? qr[31:0] : qr[63:32];
        end else begin
            y.exp_res = 32'd0; y.exp_lat = 0; y.chk_res = 1'b0;
        end
        return y;
    endfunction

    function automatic instr_t mk(bit mul, bit div, bit wsel, bit dsign, bit rsel,
                                  logic [31:0] rs1, logic [31:0] rs2, int dlat, int stall,
                                  int fl, logic [31:0] er, int el, bit eds, bit cr);
        instr_t x;
        x.mul = mul; x.div = div; x.wsel = wsel; x.dsign = dsign; x.rsel = rsel;
        x.rs1 = rs1; x.rs2 = rs2; x.dlat = dlat; x.stall = stall; x.flush_age = fl;
        x.exp_res = er; x.exp_lat = el; x.exp_dstart = eds; x.chk_res = cr;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Drives offer_q through EX one cycle at a time and checks every output
    task automatic run(input bit rnd, input int budget);
        int age, used;
        bit ready, flush, retire, in_dw, timed_out;
        used = 0; timed_out = 1'b0;
        while ((offer_q.size() > 0 || live) && !timed_out) begin
            age   = live ? cyc - entry : 0;
            ready = live && age >= cur.exp_lat;
            in_dw = live && !cur.mul && cur.div && cur.exp_dstart && age >= 1 && age <= cur.dlat;
            ex_is_mul_inst = cur.mul;  ex_is_div_inst = cur.div;  ex_word_sel = cur.wsel;
            ex_div_sign    = cur.dsign; ex_div_res_sel = cur.rsel;
            ex_rs1 = cur.rs1; ex_rs2 = cur.rs2;
            id_ex_valid = (offer_q.size() > 0) && (!rnd || $urandom_range(3, 0) != 0);
            if (rnd) mem_allowin = ($urandom_range(3, 0) != 0);
            else if (ready && stall_left > 0) begin mem_allowin = 1'b0; stall_left--; end
            else mem_allowin = 1'b1;
            flush = (live && age == cur.flush_age) || (rnd && $urandom_range(39, 0) == 0);
            pipe_flush = flush;
            stray_done = rnd ? (!in_dw && $urandom_range(15, 0) == 0) : flushed_last;
            flushed_last = 1'b0;
            @(negedge clk);
            chk("ex_valid", ex_valid, live);
            chk("ex_mem_valid", ex_mem_valid, ready);
            chk("ex_allowin", ex_allowin, !live || (ready && mem_allowin));
            chk("mul_start", mul_start, live && cur.mul && age == 0 && !flush);
            chk("div_start", div_start,
                live && !cur.mul && cur.div && cur.exp_dstart && age == 0 && !flush);
            chk("div_cancel", div_cancel, flush && in_dw);
            chk("mdu_busy", mdu_busy, live && (cur.mul || cur.div) && age >= 1);
            if (ready && cur.chk_res) chk("mdu_result", mdu_result, cur.exp_res);
            @(posedge clk);
            retire = live && ready && mem_allowin;
            if (flush) begin
                live = 1'b0; flushed_last = 1'b1;
            end else if ((!live || retire) && id_ex_valid) begin
                cur = offer_q.pop_front(); live = 1'b1; entry = cyc + 1; stall_left = cur.stall;
            end else if (retire) begin
                live = 1'b0;
            end
            cyc++; used++;
            if (used >= budget) timed_out = 1'b1;
            #1;
        end
        chk("run_budget", timed_out, 1'b0);
    endtask

    initial begin
        instr_t tbl[$];
        instr_t x;
        rst_n = 1'b0; pipe_flush = 1'b0; id_ex_valid = 1'b0; mem_allowin = 1'b0;
        stray_done = 1'b0; live = 1'b0; flushed_last = 1'b0; cyc = 0; stall_left = 0;
        cur = mk(0, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0, -1, 32'd0, 0, 0, 0);
        ex_is_mul_inst = 1'b0; ex_is_div_inst = 1'b0; ex_word_sel = 1'b0;
        ex_div_sign = 1'b0; ex_div_res_sel = 1'b0; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_mem_valid", ex_mem_valid, 1'b0);
        chk("rst_busy", mdu_busy, 1'b0);
        chk("rst_result", mdu_result, 32'd0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_div_cancel", div_cancel, 1'b0);
        @(posedge clk); #1;

        //       mul div ws sg rs  rs1            rs2            dlat st fl  exp_res        lat ds cr
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'd3,         32'hFFFF_FFFE, 1,  0, -1, 32'hFFFF_FFFA, 3,  0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 32'd3,         32'hFFFF_FFFE, 1,  0, -1, 32'h0000_0002, 3,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'd9,         32'd9,         1,  0, -1, 32'd0,         0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'd7,         32'd0,         1,  0, -1, 32'hFFFF_FFFF, 1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'd7,         32'd0,         1,  0, -1, 32'd7,         1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1,  0, -1, 32'h8000_0000, 1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1,  0, -1, 32'd0,         1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'd100,       32'd7,         10, 3, -1, 32'd14,        11, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'd100,       32'd7,         1,  0, -1, 32'd2,         2,  1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 2,  0, -1, 32'd0,         3,  1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'hFFFF_FFF9, 32'd2,         3,  0, -1, 32'hFFFF_FFFD, 4,  1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'hFFFF_FFF9, 32'd2,         3,  0, -1, 32'hFFFF_FFFF, 4,  1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'd100,       32'd7,         10, 0, 2,  32'd0,         11, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'd100,       32'd7,         3,  0, -1, 32'd2,         4,  1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'd5,         32'd6,         1,  0, -1, 32'd30,        3,  0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'd5,         32'd6,         1,  0, 0,  32'd0,         3,  0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h8000_0000, 32'd0,         1,  0, -1, 32'h8000_0000, 1,  0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  2, -1, 32'hFFFF_FFFE, 3,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'd1,         32'd2,         1,  0, -1, 32'd0,         0,  0, 0));
        foreach (tbl[i]) offer_q.push_back(tbl[i]);
        run(1'b0, 600);

        // Reset mid-stream wins over a pending instruction and clears the held result
        rst_n = 1'b0; pipe_flush = 1'b0; stray_done = 1'b0; id_ex_valid = 1'b1;
        ex_is_mul_inst = 1'b1; mem_allowin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_ex_valid", ex_valid, 1'b0);
        chk("rst2_result", mdu_result, 32'd0);
        chk("rst2_busy", mdu_busy, 1'b0);
        chk("rst2_mul_start", mul_start, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1; id_ex_valid = 1'b0; live = 1'b0; flushed_last = 1'b0;

        for (int i = 0; i < 300; i++) begin
            x = mk(0, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0, -1, 32'd0, 0, 0, 0);
            x.mul = ($urandom_range(2, 0) == 0);
            x.div = ($urandom_range(1, 0) == 1);
            x.wsel = $urandom_range(1, 0); x.dsign = $urandom_range(1, 0);
            x.rsel = $urandom_range(1, 0);
            case ($urandom_range(3, 0))
                0:       x.rs1 = 32'h8000_0000;
                1:       x.rs1 = $urandom_range(200, 0);
                default: x.rs1 = $urandom;
            endcase
            case ($urandom_range(4, 0))
                0:       x.rs2 = 32'd0;
                1:       x.rs2 = 32'hFFFF_FFFF;
                2:       x.rs2 = $urandom_range(20, 1);
                default: x.rs2 = $urandom;
            endcase
            x.dlat = $urandom_range(12, 1);
            offer_q.push_back(ref_model(x));
        end
        run(1'b1, 8000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mdu_ctrl.md
# ex_mdu_ctrl

EX-stage sequencer for the shared multiply/divide resources. It owns the EX valid bit and the EX side of the valid/allowin handshake. It issues start/cancel to an external fixed-latency multiplier and an iterative divider, resolves RISC-V divide corner cases without the divider, and holds the selected result until MEM accepts it. It sits between the ID/EX pipeline register (`ex_*` fields, `id_ex_valid`) and the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, datapath width
- MUL_LAT, 2, multiplier latency in cycles from `mul_start` to a valid `mul_product` (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- pipe_flush  in  1  flush; kills the EX instruction and any in-flight operation
- id_ex_valid  in  1  ID offers an instruction to EX
- ex_allowin  out  1  EX can accept this cycle
- ex_valid  out  1  EX holds a live instruction (register)
- ex_mem_valid  out  1  EX result ready for MEM
- mem_allowin  in  1  MEM accepts this cycle
- ex_is_mul_inst, ex_is_div_inst  in  1 each  op class of the EX instruction
- ex_word_sel  in  1  0 = LOW half of product, 1 = HIGH half
- ex_div_sign  in  1  1 = signed divide
- ex_div_res_sel  in  1  0 = QUOTIENT, 1 = REMAINDER
- ex_rs1, ex_rs2  in  XLEN  operands (dividend, divisor)
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_product  in  2*XLEN  multiplier result
- div_start  out  1  one-cycle start pulse to the divider
- div_cancel  out  1  one-cycle abort pulse to the divider
- div_done  in  1  divider result valid (pulse)
- div_quotient, div_remainder  in  XLEN  divider results
- mdu_busy  out  1  state ≠ IDLE
- mdu_result  out  XLEN  registered selected result

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE. A 2-bit state register plus a down-counter `cnt` sized for MUL_LAT.
- `ex_ready_go` = 1 when ex_valid and neither mul nor div; else 1 only in DONE.
- `ex_allowin` = !ex_valid | (ex_ready_go & mem_allowin).
- `ex_mem_valid` = ex_valid & ex_ready_go.
- ex_valid: reset → 0; else pipe_flush → 0; else if ex_allowin → id_ex_valid; else hold.
- IDLE, ex_valid & mul & !pipe_flush: `mul_start`=1, cnt←MUL_LAT-1, → MUL_WAIT.
- MUL_WAIT: cnt decrements. When cnt==0, capture `mdu_result` ← word_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0], → DONE.
- IDLE, ex_valid & div & !pipe_flush: fast path or divider path.
  - rs2==0: capture quotient = all-ones, remainder = rs1; → DONE; no div_start.
  - ex_div_sign & rs1==1<<(XLEN-1) & rs2==all-ones: capture quotient = rs1, remainder = 0; → DONE; no div_start.
  - Otherwise: `div_start`=1, → DIV_WAIT.
  - Fast-path result selection follows `ex_div_res_sel`.
- DIV_WAIT: on div_done, capture quotient/remainder per `ex_div_res_sel`, → DONE. Stay otherwise; there is no timeout.
- DONE: hold `mdu_result`. When mem_allowin, → IDLE. This is the same edge at which the next instruction loads, so the next instruction starts the following cycle.
- pipe_flush, any state: → IDLE, cnt←0, starts suppressed. `div_cancel`=1 combinationally in that cycle iff state==DIV_WAIT. A late `mul_product` is ignored.
- div_done outside DIV_WAIT is ignored.
- mul and div both set is illegal; mul takes priority.

## Timing
- Reset values: ex_valid 0, state IDLE, cnt 0, mdu_result 0, mdu_busy 0. All pulses (mul_start, div_start, div_cancel) are 0.
- Start pulses are combinational in the first EX cycle T and last exactly one cycle.
- Mul: product sampled at end of T+MUL_LAT; ex_mem_valid=1 from T+MUL_LAT+1. EX occupancy is MUL_LAT+1 cycles minimum.
- Div fast path: ex_mem_valid=1 at T+1.
- Divider path: div_done at cycle D gives ex_mem_valid=1 at D+1.
- Non-MDU instruction: ex_mem_valid in T (zero added latency).
- DONE with mem_allowin=0: ex_mem_valid and mdu_result held stable indefinitely.
- Reset has priority over flush; flush has priority over all handshakes.

## Test plan
- MUL_LAT=2, rs1=3, rs2=0xFFFFFFFE, word_sel=0 → mul_start at T, ex_mem_valid at T+3, mdu_result=0xFFFFFFFA. With word_sel=1 and product 0x00000002_FFFFFFFA → 0x00000002.
- Div rs1=7, rs2=0, res_sel=0 → no div_start, result 0xFFFFFFFF at T+1. With res_sel=1 → 7.
- Signed div rs1=0x80000000, rs2=0xFFFFFFFF → quotient 0x80000000 at T+1; REMAINDER → 0; no div_start.
- Div rs1=100, rs2=7, div_done at T+10 with q=14, r=2, mem_allowin=0 for 3 cycles → result 14 held; ex_allowin=0 until mem_allowin; then IDLE.
- pipe_flush in DIV_WAIT → div_cancel=1 for that cycle, ex_valid=0 next cycle. A later div_done is ignored; the next instruction starts cleanly.
- Back-to-back mul, mul with mem_allowin=1 → second mul_start exactly one cycle after the first's handshake edge; no double start of either instruction.
